alu32_modular: RTL and testbench
================================

Name: alu32_modular

Overview:
32-bit ALU with 16 operations: arithmetic, bitwise logic and single-bit shifts, selected by a 4-bit opcode. It is built as 32 replicated 1-bit slices with a ripple carry chain. Operand inputs are combinational into the slices; the result F and carry-out Cout are registered, giving one cycle of latency. It sits in the datapath as the execute-stage function unit.

Parameters:
- WIDTH, 32, datapath width. All behaviour below is specified for 32; other values need only elaborate.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high; clears F and Cout.
- A  input  32  operand A.
- B  input  32  operand B.
- Cin  input  1  carry-in; used only by arithmetic ops.
- DinL  input  1  serial-in bit for shift left; enters F[0].
- DinR  input  1  serial-in bit for shift right; enters F[31].
- sel  input  4  opcode. sel[3:2] selects the group, sel[1:0] selects the function within the group.
- F  output  32  registered result.
- Cout  output  1  registered carry-out.

Behaviour:
- Reset: while rst=1, F=0 and Cout=0 immediately, with no clock needed. The first update after release is at the next rising clk edge.
- Latency: 1 cycle. At each rising clk edge, F and Cout take the values computed from A, B, Cin, DinL, DinR and sel sampled at that edge. There is no handshake; an operation issues every cycle.
- Arithmetic, sel[3:2]=00: {Cout,F} = A + M + Cin, computed as a 33-bit sum, where M is chosen by sel[1:0]:
  - 00: M=0 (transfer A, or increment A when Cin=1).
  - 01: M=B (add).
  - 10: M=~B (A-B-1 when Cin=0; A-B when Cin=1).
  - 11: M=FFFFFFFF (decrement A when Cin=0).
- Arithmetic carry rules: Cout is the true carry out of bit 31. No overflow flag is produced. Wrap-around is modulo 2^32, e.g. 0-1 gives FFFFFFFF with Cout=0.
- Logic, sel[3:2]=01: sel[1:0] 00 gives A&B, 01 gives A|B, 10 gives A^B, 11 gives ~A. Cout=0.
- Shift right, sel[3:2]=10: F = {DinR, A[31:1]}. sel[1:0] is ignored. Cout=0.
- Shift left, sel[3:2]=11: F = {A[30:0], DinL}. sel[1:0] is ignored. Cout=0.
- Ignored inputs: B, Cin, DinL and DinR have no effect outside the groups that use them.
- Cout is forced to 0 for every non-arithmetic op.
- Unknown values: no X may propagate from an unused input.

Decomposition:
- Shared package alu32_pkg:
  - group constants GRP_ARITH=2'b00, GRP_LOGIC=2'b01, GRP_SHR=2'b10, GRP_SHL=2'b11.
  - function codes for sel[1:0] within each group.
- Sub-module alu32_slice, one bit, instantiated WIDTH times. Inputs: a_i, b_i, carry-in, left neighbour bit, right neighbour bit, sel. Outputs: f_i, carry-out.
  - Slice 0 takes DinL as its right-hand shift input.
  - Slice 31 takes DinR as its left-hand shift input.
- The top level holds the carry chain, Cout gating and the output register.

Test Plan:
- Reset mid-run: assert rst asynchronously while F=FFFFFFFF. F=0 and Cout=0 before the next edge, and stay 0 until the first edge after release.
- Arithmetic, result visible one edge after inputs are applied:
  - sel=0, A=FFFFFFFF, Cin=1 gives F=0, Cout=1.
  - sel=1, A=B=FFFFFFFF, Cin=0 gives F=FFFFFFFE, Cout=1.
  - sel=1, A=80000000, B=7FFFFFFF gives F=FFFFFFFF, Cout=0.
- Subtract and decrement:
  - sel=2, A=4, B=3, Cin=1 gives F=1, Cout=1; with Cin=0 gives F=0, Cout=1.
  - sel=3, A=0 gives F=FFFFFFFF, Cout=0; A=1 gives F=0, Cout=1.
- Logic, with Cin=1 driven to prove Cout stays 0:
  - A=0F0F0F0F, B=F0F0F0F0: sel=4 gives F=0; sel=5 gives F=FFFFFFFF.
  - A=AAAAAAAA, B=55555555, sel=6 gives F=FFFFFFFF.
  - A=0, sel=7 gives F=FFFFFFFF.
  - Cout=0 in every case.
- Shifts, A=12345678:
  - sel=8, DinR=0 gives F=091A2B3C.
  - sel=B, DinR=1 gives F=891A2B3C.
  - sel=C, DinL=0 gives F=2468ACF0.
  - sel=E, DinL=1 gives F=2468ACF1.
  - A=89ABCDEF, sweep all four DinL/DinR combinations: only the matching injected bit changes F.
- Random: 25+ back-to-back random A, B, Cin, DinL, DinR and sel, one per cycle, compared against a golden model delayed by one cycle. Full throughput required, with no bubbles.

Source files
------------

// File: rtl/alu32_pkg.sv
// Shared opcode encoding for the 32-bit slice ALU: sel[3:2] picks the group,
// sel[1:0] picks the function inside arithmetic and logic groups.
package alu32_pkg;

  localparam logic [1:0] GRP_ARITH = 2'b00;
  localparam logic [1:0] GRP_LOGIC = 2'b01;
  localparam logic [1:0] GRP_SHR   = 2'b10;
  localparam logic [1:0] GRP_SHL   = 2'b11;

  // Arithmetic functions: selects the M operand of A + M + Cin
  localparam logic [1:0] FN_PASS = 2'b00;
  localparam logic [1:0] FN_ADD  = 2'b01;
  localparam logic [1:0] FN_SUB  = 2'b10;
  localparam logic [1:0] FN_DEC  = 2'b11;

  localparam logic [1:0] FN_AND  = 2'b00;
  localparam logic [1:0] FN_OR   = 2'b01;
  localparam logic [1:0] FN_XOR  = 2'b10;
  localparam logic [1:0] FN_NOT  = 2'b11;

endpackage

// File: rtl/alu32_modular_if.sv
// Operand/result bundle of the ALU: the master drives operands and opcode,
// the slave (ALU) returns the registered result and carry.
interface alu32_modular_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             DinL;
  logic             DinR;
  logic [3:0]       sel;
  logic [WIDTH-1:0] F;
  logic             Cout;

  modport master (output A, B, Cin, DinL, DinR, sel, input F, Cout);
  modport slave  (input A, B, Cin, DinL, DinR, sel, output F, Cout);
endinterface

// File: rtl/alu32_slice.sv
// One bit of the ALU: full adder with selectable M operand, bitwise logic and
// neighbour selection for single-bit shifts. Purely combinational.
module alu32_slice
  import alu32_pkg::*;
(
  input  logic       a_i,
  input  logic       b_i,
  input  logic       cin_i,
  input  logic       left_i,   // bit to the left (A[i+1], or DinR at the MSB)
  input  logic       right_i,  // bit to the right (A[i-1], or DinL at the LSB)
  input  logic [3:0] sel_i,
  output logic       f_o,
  output logic       cout_o
);

  logic m;
  logic logic_f;

  always_comb begin
    m = 1'b0;
    case (sel_i[1:0])
      FN_PASS: m = 1'b0;
      FN_ADD:  m = b_i;
      FN_SUB:  m = ~b_i;
      FN_DEC:  m = 1'b1;
      default: m = 1'b0;
    endcase
  end

  always_comb begin
    logic_f = 1'b0;
    case (sel_i[1:0])
      FN_AND:  logic_f = a_i & b_i;
      FN_OR:   logic_f = a_i | b_i;
      FN_XOR:  logic_f = a_i ^ b_i;
      FN_NOT:  logic_f = ~a_i;
      default: logic_f = 1'b0;
    endcase
  end

  always_comb begin
    f_o = 1'b0;
    case (sel_i[3:2])
      GRP_ARITH: f_o = a_i ^ m ^ cin_i;
      GRP_LOGIC: f_o = logic_f;
      GRP_SHR:   f_o = left_i;
      GRP_SHL:   f_o = right_i;
      default:   f_o = 1'b0;
    endcase
  end

  // Carry is meaningful only for arithmetic; the top gates it otherwise.
  assign cout_o = (a_i & m) | (cin_i & (a_i ^ m));

endmodule

// File: rtl/alu32_modular.sv
// Execute-stage ALU: WIDTH replicated slices on a ripple carry chain, with the
// result and carry-out registered (one cycle latency, one op per cycle).
module alu32_modular
  import alu32_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  alu32_modular_if.slave     bus
);

  logic [WIDTH:0]   carry;
  logic [WIDTH+1:0] a_ext;
  logic [WIDTH-1:0] f_d, f_q;
  logic             cout_d, cout_q;

  // Serial-in bits sit at the ends so every slice sees uniform neighbours.
  assign a_ext    = {bus.DinR, bus.A, bus.DinL};
  assign carry[0] = bus.Cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_slice
    alu32_slice u_slice (
      .a_i     (bus.A[i]),
      .b_i     (bus.B[i]),
      .cin_i   (carry[i]),
      .left_i  (a_ext[i+2]),
      .right_i (a_ext[i]),
      .sel_i   (bus.sel),
      .f_o     (f_d[i]),
      .cout_o  (carry[i+1])
    );
  end

  assign cout_d = (bus.sel[3:2] == GRP_ARITH) ? carry[WIDTH] : 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_q    <= '0;
      cout_q <= 1'b0;
    end else begin
      f_q    <= f_d;
      cout_q <= cout_d;
    end
  end

  assign bus.F    = f_q;
  assign bus.Cout = cout_q;

endmodule

// File: tb/tb_alu32_modular.sv
// Self-checking bench for alu32_modular: directed corner cases plus a random
// back-to-back stream checked against an arithmetic reference model.
module tb_alu32_modular;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  alu32_modular_if #(.WIDTH(32)) alu_if ();

  alu32_modular #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (alu_if.slave)
  );

  always #5 clk = ~clk;

  // Reference: {Cout, F} from plain 33-bit arithmetic and shift operators.
  function automatic logic [32:0] ref_op(input logic [31:0] a, input logic [31:0] b,
                                         input logic cin, input logic dl, input logic dr,
                                         input logic [3:0] sel);
    logic [32:0] r;
    logic [32:0] m;
    r = '0;
    case (sel)
      4'h0, 4'h1, 4'h2, 4'h3: begin
        m = (sel == 4'h0) ? 33'h0 : (sel == 4'h1) ? {1'b0, b} :
            (sel == 4'h2) ? {1'b0, ~b} : 33'h0_FFFF_FFFF;
        r = {1'b0, a} + m + {32'h0, cin};
      end
      4'h4: r = {1'b0, a & b};
      4'h5: r = {1'b0, a | b};
      4'h6: r = {1'b0, a ^ b};
      4'h7: r = {1'b0, ~a};
      4'h8, 4'h9, 4'hA, 4'hB: r = {1'b0, (a >> 1) | ({31'h0, dr} << 31)};
      default: r = {1'b0, (a << 1) | {31'h0, dl}};
    endcase
    return r;
  endfunction

  // Drive operands right after a sampling point, then sample #1 after the edge.
  task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic cin,
                       input logic dl, input logic dr, input logic [3:0] sel);
    alu_if.A    = a;
    alu_if.B    = b;
    alu_if.Cin  = cin;
    alu_if.DinL = dl;
    alu_if.DinR = dr;
    alu_if.sel  = sel;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if (alu_if.F !== 32'h0 || alu_if.Cout !== 1'b0) begin
      errors++;
      $display("FAIL reset_initial: F=%h Cout=%b, expected F=00000000 Cout=0", alu_if.F, alu_if.Cout);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    // Mid-run reset while F holds all ones
    apply(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h3);
    checks++;
    if (alu_if.F !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL reset_prefill: F=%h, expected FFFFFFFF", alu_if.F);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (alu_if.F !== 32'h0 || alu_if.Cout !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: F=%h Cout=%b, expected 0/0 before edge", alu_if.F, alu_if.Cout);
    end
    alu_if.A = 32'hFFFF_FFFF;
    alu_if.Cin = 1'b1;
    alu_if.sel = 4'h0;
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (alu_if.F !== 32'h0 || alu_if.Cout !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: F=%h Cout=%b, expected 0/0 until edge after release", alu_if.F, alu_if.Cout);
    end
    @(posedge clk);
    #1;
    checks++;
    if (alu_if.F !== 32'h0 || alu_if.Cout !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_op: F=%h Cout=%b, expected 00000000/1", alu_if.F, alu_if.Cout);
    end
  endtask

  task automatic test_arith;
    logic [31:0] ea [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
    logic [31:0] eb [3] = '{32'h1234_5678, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
    logic        ec [3] = '{1'b1, 1'b0, 1'b0};
    logic [3:0]  es [3] = '{4'h0, 4'h1, 4'h1};
    logic [31:0] ef [3] = '{32'h0, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
    logic        eo [3] = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      apply(ea[i], eb[i], ec[i], 1'b1, 1'b1, es[i]);
      checks++;
      if (alu_if.F !== ef[i] || alu_if.Cout !== eo[i]) begin
        errors++;
        $display("FAIL arith_%0d: F=%h Cout=%b, expected F=%h Cout=%b", i, alu_if.F, alu_if.Cout, ef[i], eo[i]);
      end
    end
  endtask

  task automatic test_sub_dec;
    logic [31:0] ea [4] = '{32'h4, 32'h4, 32'h0, 32'h1};
    logic        ec [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic [3:0]  es [4] = '{4'h2, 4'h2, 4'h3, 4'h3};
    logic [31:0] ef [4] = '{32'h1, 32'h0, 32'hFFFF_FFFF, 32'h0};
    logic        eo [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      apply(ea[i], 32'h3, ec[i], 1'b0, 1'b0, es[i]);
      checks++;
      if (alu_if.F !== ef[i] || alu_if.Cout !== eo[i]) begin
        errors++;
        $display("FAIL subdec_%0d: F=%h Cout=%b, expected F=%h Cout=%b", i, alu_if.F, alu_if.Cout, ef[i], eo[i]);
      end
    end
  endtask

  task automatic test_logic;
    logic [31:0] ea [4] = '{32'h0F0F_0F0F, 32'h0F0F_0F0F, 32'hAAAA_AAAA, 32'h0};
    logic [31:0] eb [4] = '{32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'h5555_5555, 32'hFFFF_FFFF};
    logic [3:0]  es [4] = '{4'h4, 4'h5, 4'h6, 4'h7};
    logic [31:0] ef [4] = '{32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    for (int i = 0; i < 4; i++) begin
      apply(ea[i], eb[i], 1'b1, 1'b1, 1'b1, es[i]);
      checks++;
      if (alu_if.F !== ef[i] || alu_if.Cout !== 1'b0) begin
        errors++;
        $display("FAIL logic_%0d: F=%h Cout=%b, expected F=%h Cout=0", i, alu_if.F, alu_if.Cout, ef[i]);
      end
    end
  endtask

  task automatic test_shift;
    logic [3:0]  es [4] = '{4'h8, 4'hB, 4'hC, 4'hE};
    logic        dl [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic        dr [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [31:0] ef [4] = '{32'h091A_2B3C, 32'h891A_2B3C, 32'h2468_ACF0, 32'h2468_ACF1};
    for (int i = 0; i < 4; i++) begin
      apply(32'h1234_5678, 32'hFFFF_FFFF, 1'b1, dl[i], dr[i], es[i]);
      checks++;
      if (alu_if.F !== ef[i] || alu_if.Cout !== 1'b0) begin
        errors++;
        $display("FAIL shift_%0d: F=%h Cout=%b, expected F=%h Cout=0", i, alu_if.F, alu_if.Cout, ef[i]);
      end
    end
  endtask

  task automatic test_din_sweep;
    logic [31:0] a = 32'h89AB_CDEF;
    logic [31:0] exp_f;
    for (int k = 0; k < 4; k++) begin
      logic l = k[0];
      logic r = k[1];
      apply(a, 32'h0, 1'b0, l, r, 4'h9);
      exp_f = 32'h44D5_E6F7 | (r ? 32'h8000_0000 : 32'h0);
      checks++;
      if (alu_if.F !== exp_f) begin
        errors++;
        $display("FAIL din_shr_%0d: F=%h, expected %h", k, alu_if.F, exp_f);
      end
      apply(a, 32'h0, 1'b0, l, r, 4'hD);
      exp_f = 32'h1357_9BDE | (l ? 32'h1 : 32'h0);
      checks++;
      if (alu_if.F !== exp_f) begin
        errors++;
        $display("FAIL din_shl_%0d: F=%h, expected %h", k, alu_if.F, exp_f);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [32:0] pend [$];
    logic [32:0] exp_v;
    logic [31:0] a, b;
    logic        cin, dl, dr;
    logic [3:0]  sel;
    for (int n = 0; n < 41; n++) begin
      if (n < 40) begin
        a   = $urandom;
        b   = $urandom;
        cin = 1'($urandom_range(0, 1));
        dl  = 1'($urandom_range(0, 1));
        dr  = 1'($urandom_range(0, 1));
        sel = 4'($urandom_range(0, 15));
        if (n % 8 == 0) a = 32'hFFFF_FFFF;
        pend.push_back(ref_op(a, b, cin, dl, dr, sel));
        alu_if.A = a; alu_if.B = b; alu_if.Cin = cin;
        alu_if.DinL = dl; alu_if.DinR = dr; alu_if.sel = sel;
      end
      @(posedge clk);
      #1;
      // Every edge retires exactly the operation issued just before it.
      if (pend.size() > 0) begin
        exp_v = pend.pop_front();
        checks++;
        if (alu_if.F !== exp_v[31:0] || alu_if.Cout !== exp_v[32]) begin
          errors++;
          $display("FAIL random_%0d: F=%h Cout=%b, expected F=%h Cout=%b",
                   n, alu_if.F, alu_if.Cout, exp_v[31:0], exp_v[32]);
        end
      end
    end
  endtask

  initial begin
    alu_if.A = '0; alu_if.B = '0; alu_if.Cin = 1'b0;
    alu_if.DinL = 1'b0; alu_if.DinR = 1'b0; alu_if.sel = 4'h0;
    test_reset;
    test_arith;
    test_sub_dec;
    test_logic;
    test_shift;
    test_din_sweep;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
